regfile_wb_controller: RTL and testbench

//  Drives the write port of the 32x32 register file and bypasses its read ports.

---
 rtl/regfile_wb_controller_if.sv | 48 ++++
 rtl/regfile_wb_controller.sv | 156 +++++++++++++++
 tb/tb_regfile_wb_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_controller_if.sv
// Bundles the signals between regfile_wb_controller and its surroundings.
// These are the ALU and multdiv write-back producers, the decode operand
// lookup, and the register file read/write ports.
// The controller uses the slave modport; the pipeline/regfile side uses master.
interface regfile_wb_controller_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_wb_valid;
    logic [4:0]       alu_wb_reg;
    logic [31:0]      alu_wb_data;
    logic             alu_stall;
    logic             md_valid;
    logic             md_ready;
    logic [4:0]       md_reg;
    logic [31:0]      md_data;
    logic [4:0]       rd_regA;
    logic [4:0]       rd_regB;
    logic [31:0]      operand_A;
    logic [31:0]      operand_B;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic [4:0]       ctrl_readRegA;
    logic [4:0]       ctrl_readRegB;
    logic [31:0]      data_readRegA;
    logic [31:0]      data_readRegB;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output alu_wb_valid, alu_wb_reg, alu_wb_data,
        output md_valid, md_reg, md_data,
        output rd_regA, rd_regB, data_readRegA, data_readRegB,
        input  alu_stall, md_ready, operand_A, operand_B,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB, fifo_count
    );

    modport slave (
        input  alu_wb_valid, alu_wb_reg, alu_wb_data,
        input  md_valid, md_reg, md_data,
        input  rd_regA, rd_regB, data_readRegA, data_readRegB,
        output alu_stall, md_ready, operand_A, operand_B,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB, fifo_count
    );
endinterface

// File: rtl/regfile_wb_controller.sv
// Write-back controller for the 32x32 register file.
// The single-cycle ALU always wins the write port. Multdiv results wait in a
// small in-order FIFO and retire when the ALU is idle.
// If the FIFO sits full while the ALU keeps writing for STARVE_MAX cycles,
// the controller enters DRAIN. In DRAIN the ALU is stalled until the FIFO
// empties.
// Operand reads forward in-flight data ahead of the stored register value.
module regfile_wb_controller #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clock_i,
    input  logic                   ctrl_reset_i,
    regfile_wb_controller_if.slave bus_io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

    typedef enum logic {
        ST_NORMAL,
        ST_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [4:0]       entryReg_q  [DEPTH];
    logic [31:0]      entryData_q [DEPTH];

    logic             aluIssue;
    logic             popHead;
    logic             pushEntry;
    logic             mdReady;
    logic             writeEnable;
    logic [4:0]       writeReg;
    logic [31:0]      writeData;
    logic [PTR_W-1:0] scanIdx;
    logic [31:0]      operandA;
    logic [31:0]      operandB;

    // Pick this cycle's write-port owner: the ALU in NORMAL, otherwise the FIFO head.
    // r0 writes are issued (and a head popped) but never reach the port.
    always_comb begin
        aluIssue    = 1'b0;
        popHead     = 1'b0;
        writeEnable = 1'b0;
        writeReg    = 5'd0;
        writeData   = 32'd0;
        if (ctrl_reset_i) begin
            if (state_q == ST_NORMAL && bus_io.alu_wb_valid) begin
                aluIssue = 1'b1;
                if (bus_io.alu_wb_reg != 5'd0) begin
                    writeEnable = 1'b1;
                    writeReg    = bus_io.alu_wb_reg;
                    writeData   = bus_io.alu_wb_data;
                end
            end else if (count_q != '0) begin
                popHead = 1'b1;
                if (entryReg_q[rdPtr_q] != 5'd0) begin
                    writeEnable = 1'b1;
                    writeReg    = entryReg_q[rdPtr_q];
                    writeData   = entryData_q[rdPtr_q];
                end
            end
        end
    end

    // FIFO bookkeeping and the starvation / drain decision for the next cycle.
    // A full FIFO refuses pushes even when it pops in the same cycle.
    always_comb begin
        mdReady   = ctrl_reset_i && (count_q < DEPTH_C);
        pushEntry = bus_io.md_valid && mdReady && (bus_io.md_reg != 5'd0);
        wrPtr_d   = pushEntry ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d   = popHead ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d   = count_q + CNT_W'(pushEntry) - CNT_W'(popHead);
        starve_d  = '0;
        state_d   = state_q;
        if (state_q == ST_NORMAL) begin
            if (count_q == DEPTH_C && aluIssue) begin
                starve_d = starve_q + STV_W'(1);
            end
            if (starve_d == STARVE_C) begin
                state_d = ST_DRAIN;
            end
        end else if (count_q == '0) begin
            state_d = ST_NORMAL;
        end
    end

    // All controller state, with synchronous active-low reset discarding queued entries.
    always_ff @(posedge clock_i) begin
        if (!ctrl_reset_i) begin
            state_q  <= ST_NORMAL;
            rdPtr_q  <= '0;
            wrPtr_q  <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (pushEntry) begin
                entryReg_q[wrPtr_q]  <= bus_io.md_reg;
                entryData_q[wrPtr_q] <= bus_io.md_data;
            end
        end
    end

    // Operand forwarding priority: r0, youngest queued entry (head included), ALU write, regfile.
    always_comb begin
        operandA = bus_io.data_readRegA;
        operandB = bus_io.data_readRegB;
        scanIdx  = rdPtr_q;
        if (aluIssue && bus_io.alu_wb_reg == bus_io.rd_regA) begin
            operandA = bus_io.alu_wb_data;
        end
        if (aluIssue && bus_io.alu_wb_reg == bus_io.rd_regB) begin
            operandB = bus_io.alu_wb_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = rdPtr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (entryReg_q[scanIdx] == bus_io.rd_regA) begin
                    operandA = entryData_q[scanIdx];
                end
                if (entryReg_q[scanIdx] == bus_io.rd_regB) begin
                    operandB = entryData_q[scanIdx];
                end
            end
        end
        if (bus_io.rd_regA == 5'd0) begin
            operandA = 32'd0;
        end
        if (bus_io.rd_regB == 5'd0) begin
            operandB = 32'd0;
        end
    end

    assign bus_io.alu_stall        = ctrl_reset_i && (state_q == ST_DRAIN);
    assign bus_io.md_ready         = mdReady;
    assign bus_io.ctrl_writeEnable = writeEnable;
    assign bus_io.ctrl_writeReg    = writeReg;
    assign bus_io.data_writeReg    = writeData;
    assign bus_io.ctrl_readRegA    = bus_io.rd_regA;
    assign bus_io.ctrl_readRegB    = bus_io.rd_regB;
    assign bus_io.operand_A        = operandA;
    assign bus_io.operand_B        = operandB;
    assign bus_io.fifo_count       = count_q;
endmodule

// File: tb/tb_regfile_wb_controller.sv
// Scoreboard bench for regfile_wb_controller.
// A queue-based reference model predicts each cycle's status, operands and
// register writes. A negedge monitor compares them against the DUT.
module tb_regfile_wb_controller;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    typedef struct {
        bit          we;
        bit          mdReady;
        bit          stall;
        int          count;
        bit          chkOps;
        logic [4:0]  rdA;
        logic [4:0]  rdB;
        logic [31:0] opA;
        logic [31:0] opB;
    } status_t;

    logic        clock     = 1'b0;
    logic        ctrlReset = 1'b0;
    logic [31:0] modelRf [32];
    entry_t      mdQ[$];
    entry_t      writeQ[$];
    status_t     statusQ[$];
    bit          drain;
    int          starve;
    bit          pendWe;
    entry_t      pendW;
    bit          recording;
    int          checks   = 0;
    int          failures = 0;

    regfile_wb_controller_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_controller #(
        .DEPTH(DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock_i(clock),
        .ctrl_reset_i(ctrlReset),
        .bus_io(bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    assign bus.data_readRegA = modelRf[bus.ctrl_readRegA];
    assign bus.data_readRegB = modelRf[bus.ctrl_readRegB];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural value of a register as a reader should see it this cycle.
    function automatic logic [31:0] refOperand(input logic [4:0] r, input bit aluW,
                                               input logic [4:0] ar, input logic [31:0] ad);
        if (r == 5'd0) return 32'd0;
        for (int i = mdQ.size() - 1; i >= 0; i--) begin
            if (mdQ[i].r == r) return mdQ[i].d;
        end
        if (aluW && ar == r) return ad;
        return modelRf[r];
    endfunction

    // Drive one cycle of inputs, queue the model's expectations, advance the model.
    task automatic applyStimulus(input bit rstn, input bit av, input logic [4:0] ar,
                                 input logic [31:0] ad, input bit mv, input logic [4:0] mr,
                                 input logic [31:0] mdd, input logic [4:0] ra, input logic [4:0] rb);
        status_t st;
        entry_t  w;
        entry_t  pushed;
        bit      aluIssued;
        bit      popped;
        int      sizeBefore;
        @(posedge clock);
        #1;
        if (pendWe) begin
            modelRf[pendW.r] = pendW.d;
            pendWe = 1'b0;
        end
        ctrlReset        = rstn;
        bus.alu_wb_valid = av;
        bus.alu_wb_reg   = ar;
        bus.alu_wb_data  = ad;
        bus.md_valid     = mv;
        bus.md_reg       = mr;
        bus.md_data      = mdd;
        bus.rd_regA      = ra;
        bus.rd_regB      = rb;

        aluIssued  = 1'b0;
        popped     = 1'b0;
        w          = '0;
        sizeBefore = mdQ.size();
        st.we      = 1'b0;
        st.count   = sizeBefore;
        st.mdReady = rstn && (sizeBefore < DEPTH);
        st.stall   = rstn && drain;
        st.chkOps  = rstn;
        st.rdA     = ra;
        st.rdB     = rb;
        st.opA     = 32'd0;
        st.opB     = 32'd0;
        if (rstn) begin
            if (!drain && av) begin
                aluIssued = 1'b1;
                w.r       = ar;
                w.d       = ad;
                st.we     = (ar != 5'd0);
            end else if (sizeBefore > 0) begin
                popped = 1'b1;
                w      = mdQ[0];
                st.we  = (w.r != 5'd0);
            end
            st.opA = refOperand(ra, aluIssued, ar, ad);
            st.opB = refOperand(rb, aluIssued, ar, ad);
        end
        if (recording) begin
            statusQ.push_back(st);
            if (st.we) writeQ.push_back(w);
        end
        if (st.we) begin
            pendWe = 1'b1;
            pendW  = w;
        end

        if (!rstn) begin
            mdQ.delete();
            drain  = 1'b0;
            starve = 0;
        end else begin
            if (popped) void'(mdQ.pop_front());
            if (mv && sizeBefore < DEPTH && mr != 5'd0) begin
                pushed.r = mr;
                pushed.d = mdd;
                mdQ.push_back(pushed);
            end
            if (!drain) begin
                starve = (sizeBefore == DEPTH && aluIssued) ? starve + 1 : 0;
                if (starve >= STARVE_MAX) drain = 1'b1;
            end else begin
                starve = 0;
                if (sizeBefore == 0) drain = 1'b0;
            end
        end
    endtask

    task automatic randomCycles(input int n, input int aluPct, input int mdPct, input int rstPct);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(99) >= rstPct, $urandom_range(99) < aluPct,
                          5'($urandom_range(7)), $urandom,
                          $urandom_range(99) < mdPct, 5'($urandom_range(7)), $urandom,
                          5'($urandom_range(7)), 5'($urandom_range(7)));
        end
    endtask

    // Monitor: pops expected status every cycle and an expected write whenever the port writes.
    always @(negedge clock) begin : monitor
        status_t s;
        entry_t  w;
        if (statusQ.size() > 0) begin
            s = statusQ.pop_front();
            checkOutput("writeEnable", 32'(bus.ctrl_writeEnable), 32'(s.we));
            checkOutput("md_ready", 32'(bus.md_ready), 32'(s.mdReady));
            checkOutput("alu_stall", 32'(bus.alu_stall), 32'(s.stall));
            checkOutput("fifo_count", 32'(bus.fifo_count), 32'(s.count));
            if (s.chkOps) begin
                checkOutput("ctrl_readRegA", 32'(bus.ctrl_readRegA), 32'(s.rdA));
                checkOutput("ctrl_readRegB", 32'(bus.ctrl_readRegB), 32'(s.rdB));
                checkOutput("operand_A", bus.operand_A, s.opA);
                checkOutput("operand_B", bus.operand_B, s.opB);
            end
        end
        if (bus.ctrl_writeEnable === 1'b1) begin
            if (writeQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedWrite: got write r%0d=0x%08h, expected no write",
                         bus.ctrl_writeReg, bus.data_writeReg);
            end else begin
                w = writeQ.pop_front();
                checkOutput("ctrl_writeReg", 32'(bus.ctrl_writeReg), 32'(w.r));
                checkOutput("data_writeReg", bus.data_writeReg, w.d);
            end
        end
    end

    // Directed scenarios first, then randomized phases with different traffic mixes.
    initial begin
        recording = 1'b0;
        drain     = 1'b0;
        starve    = 0;
        pendWe    = 1'b0;
        for (int i = 0; i < 32; i++) modelRf[i] = $urandom;
        modelRf[0] = 32'hFFFFFFFF;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_reg   = 5'd0;
        bus.alu_wb_data  = 32'd0;
        bus.md_valid     = 1'b0;
        bus.md_reg       = 5'd0;
        bus.md_data      = 32'd0;
        bus.rd_regA      = 5'd0;
        bus.rd_regB      = 5'd0;

        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
        recording = 1'b1;
        $display("[TB] reset with md_valid held high");
        repeat (3) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        $display("[TB] ALU write forwarded in the same cycle");
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);

        $display("[TB] two multdiv results to r3 behind a busy ALU");
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd3, 32'h22, 5'd0, 5'd3);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);

        $display("[TB] starvation drives the controller into DRAIN");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 5'(20 + i), $urandom, 1'b1, 5'(10 + i), $urandom, 5'd10, 5'd13);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 1'b1, 5'd24, $urandom, 1'b1, 5'd14, $urandom, 5'd12, 5'd24);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, 5'd25, $urandom, 1'b0, 5'd0, 32'd0, 5'd13, 5'd25);

        $display("[TB] r0 handling");
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        $display("[TB] reset while draining");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 5'd26, $urandom, 1'b1, 5'(16 + i), $urandom, 5'd16, 5'd0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b1, 5'd27, $urandom, 1'b0, 5'd0, 32'd0, 5'd17, 5'd0);
        repeat (2) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd18, 5'd19);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd18, 5'd19);
        repeat (4) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd18, 5'd19);

        $display("[TB] randomized traffic");
        randomCycles(200, 50, 50, 1);
        randomCycles(200, 95, 90, 0);
        randomCycles(150, 20, 60, 2);
        repeat (12) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);

        @(negedge clock);
        @(negedge clock);
        checkOutput("pendingWrites", 32'(writeQ.size()), 32'd0);
        checkOutput("pendingStatus", 32'(statusQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
